// File: rtl/serial_shift_out_with_display.sv
`default_nettype none
// ============================================================================
// Module      : serial_shift_out_with_display
// Description : Parallel-in / serial-out transmitter. Loads an 8-bit word from
//               SW[7:0] and shifts it out MSB-first on SER_OUT, one bit per
//               step event (debounced KEY[1] press or internal auto-tick),
//               with a one-cycle SER_VALID strobe per bit. Shows the shift
//               register, busy/done flags and state/bit-count on LEDs and
//               7-segment displays.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_shift_out_with_display #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int TICK_DIV     = 50000000
) (
    input  logic       CLOCK_50,
    input  logic [1:0] KEY,
    input  logic [9:0] SW,
    output logic       SER_OUT,
    output logic       SER_VALID,
    output logic [9:0] LEDR,
    output logic [7:0] HEX1,
    output logic [7:0] HEX0
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_db_w   = $clog2(DEBOUNCE_CYC + 1);
    localparam int c_tick_w = $clog2(TICK_DIV + 1);

    localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DEBOUNCE_CYC - 1);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);

    localparam logic [3:0] c_word_bits = 4'd8;
    localparam logic [7:0] c_seg_zero  = 8'hC0;

    // State encoding doubles as the code shown on HEX1.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic                w_rst_n;

    logic [1:0]          r_key_sync;
    logic [1:0]          r_load_sync;
    logic [1:0]          r_auto_sync;
    logic                r_load_prev;
    logic                w_load_evt;

    logic                r_db_level;
    logic [c_db_w-1:0]   r_db_cnt;
    logic                r_key_step;

    logic [c_tick_w-1:0] r_tick_cnt;
    logic                w_tick;
    logic                w_step;

    state_t              r_state;
    state_t              w_state_next;

    logic [7:0]          r_shreg;
    logic [3:0]          r_cnt;
    logic                r_ser_out;
    logic                r_ser_valid;

    logic [9:0]          r_ledr;
    logic [7:0]          r_hex0;
    logic [7:0]          r_hex1;

    assign w_rst_n = KEY[0];

    // ------------------------------------------------------------------------
    // Active-low 7-segment encoding for digits 0..8 (decimal point off).
    // ------------------------------------------------------------------------
    function automatic logic [7:0] seg(input logic [3:0] value);
        logic [7:0] pattern;
        case (value)
            4'd0:    pattern = 8'hC0;
            4'd1:    pattern = 8'hF9;
            4'd2:    pattern = 8'hA4;
            4'd3:    pattern = 8'hB0;
            4'd4:    pattern = 8'h99;
            4'd5:    pattern = 8'h92;
            4'd6:    pattern = 8'h82;
            4'd7:    pattern = 8'hF8;
            4'd8:    pattern = 8'h80;
            default: pattern = 8'hFF;
        endcase
        return pattern;
    endfunction

    // ------------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous button and switches.
    // The button synchronizer idles at 1 (released).
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_key_sync  <= 2'b11;
            r_load_sync <= 2'b00;
            r_auto_sync <= 2'b00;
            r_load_prev <= 1'b0;
        end else begin
            r_key_sync  <= {r_key_sync[0],  KEY[1]};
            r_load_sync <= {r_load_sync[0], SW[8]};
            r_auto_sync <= {r_auto_sync[0], SW[9]};
            r_load_prev <= r_load_sync[1];
        end
    end

    // A load request is the rising edge of the synchronized SW[8].
    assign w_load_evt = r_load_sync[1] & ~r_load_prev;

    // ------------------------------------------------------------------------
    // Debouncer: the level follows the synchronized key only after
    // DEBOUNCE_CYC consecutive samples that differ from it; a 1->0 update
    // emits a one-cycle manual step pulse.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_db_level <= 1'b1;
            r_db_cnt   <= '0;
            r_key_step <= 1'b0;
        end else begin
            r_key_step <= 1'b0;
            if (r_key_sync[1] == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_db_last) begin
                r_db_cnt   <= '0;
                r_db_level <= r_key_sync[1];
                r_key_step <= ~r_key_sync[1];
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Auto-step divider: free-runs only while shifting, parked at 0 otherwise.
    // It keeps counting across a mode switch so a return to auto mode does
    // not restart the period.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tick_cnt <= '0;
        end else if (r_state != ST_SHIFT) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == c_tick_last) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick = (r_state == ST_SHIFT) && (r_tick_cnt == c_tick_last);

    // In auto mode the button is ignored entirely.
    assign w_step = r_auto_sync[1] ? w_tick : r_key_step;

    // ------------------------------------------------------------------------
    // FSM state register.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic. Loads are only honoured in IDLE and DONE, so a
    // request during LOAD/SHIFT is dropped rather than queued; in DONE a
    // load beats a simultaneous step.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load_evt) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_step && (r_cnt == 4'd1)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_load_evt) begin
                    w_state_next = ST_LOAD;
                end else if (w_step) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Shift datapath: capture the word in LOAD, emit one bit per step in
    // SHIFT. SER_OUT holds between strobes; SER_VALID is a single cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_shreg     <= 8'h00;
            r_cnt       <= 4'd0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
        end else begin
            r_ser_valid <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    r_shreg <= SW[7:0];
                    r_cnt   <= c_word_bits;
                end
                ST_SHIFT: begin
                    if (w_step && (r_cnt != 4'd0)) begin
                        r_ser_out   <= r_shreg[7];
                        r_ser_valid <= 1'b1;
                        r_shreg     <= {r_shreg[6:0], 1'b0};
                        r_cnt       <= r_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registered board outputs, one cycle behind the state and datapath.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ledr <= 10'd0;
            r_hex0 <= c_seg_zero;
            r_hex1 <= c_seg_zero;
        end else begin
            r_ledr <= {(r_state == ST_DONE), (r_state == ST_SHIFT), r_shreg};
            r_hex0 <= seg(r_cnt);
            r_hex1 <= seg({2'b00, r_state});
        end
    end

    assign SER_OUT   = r_ser_out;
    assign SER_VALID = r_ser_valid;
    assign LEDR      = r_ledr;
    assign HEX0      = r_hex0;
    assign HEX1      = r_hex1;

endmodule
`default_nettype wire

// File: tb/tb_serial_shift_out_with_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_shift_out_with_display
// Description : Directed self-checking bench for serial_shift_out_with_display
//               (DEBOUNCE_CYC=4, TICK_DIV=10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_shift_out_with_display;

    logic       clk;
    logic [1:0] KEY;
    logic [9:0] SW;
    logic       SER_OUT;
    logic       SER_VALID;
    logic [9:0] LEDR;
    logic [7:0] HEX1;
    logic [7:0] HEX0;

    int n_cmp = 0;
    int n_err = 0;

    // Monitor state, written only by the negedge collector.
    int         cyc = 0;
    int         nstrobe = 0;
    logic [7:0] bits = 8'h00;
    int         strobe_cyc [0:63];
    int         shift_rise_cyc = 0;
    int         done_rise_cyc = 0;
    logic       prev_l8 = 1'b0;
    logic       prev_l9 = 1'b0;

    // Hand-written active-low digit patterns 0..8.
    logic [7:0] seg_tab [0:8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80};

    serial_shift_out_with_display #(
        .DEBOUNCE_CYC(4),
        .TICK_DIV    (10)
    ) dut (
        .CLOCK_50 (clk),
        .KEY      (KEY),
        .SW       (SW),
        .SER_OUT  (SER_OUT),
        .SER_VALID(SER_VALID),
        .LEDR     (LEDR),
        .HEX1     (HEX1),
        .HEX0     (HEX0)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Collect serial bits, strobe times and busy/done rising edges.
    always @(negedge clk) begin
        cyc     <= cyc + 1;
        prev_l8 <= LEDR[8];
        prev_l9 <= LEDR[9];
        if (SER_VALID === 1'b1) begin
            bits    <= {bits[6:0], SER_OUT};
            nstrobe <= nstrobe + 1;
            if (nstrobe < 64) strobe_cyc[nstrobe] <= cyc;
        end
        if (LEDR[8] && !prev_l8) shift_rise_cyc <= cyc;
        if (LEDR[9] && !prev_l9) done_rise_cyc <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        KEY[1] = 1'b0;
        cycles(10);
        KEY[1] = 1'b1;
        cycles(10);
    endtask

    task automatic do_load(input logic [7:0] d);
        SW[7:0] = d;
        SW[8]   = 1'b1;
        cycles(6);
        SW[8]   = 1'b0;
        cycles(2);
    endtask

    task automatic wait_strobes(input int target, input int limit);
        int k = 0;
        while (nstrobe < target && k < limit) begin
            cycles(1);
            k++;
        end
        check("strobe_wait", nstrobe, target);
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (LEDR[9] !== 1'b1 && k < limit) begin
            cycles(1);
            k++;
        end
        check("done_wait", {31'd0, LEDR[9]}, 32'd1);
        cycles(2);
    endtask

    initial begin
        int base;
        int seen;
        KEY = 2'b11;
        SW  = 10'd0;

        // 1. Reset
        @(negedge clk);
        KEY[0] = 1'b0;
        cycles(3);
        check("rst_ser_out", {31'd0, SER_OUT}, 32'd0);
        check("rst_ser_valid", {31'd0, SER_VALID}, 32'd0);
        check("rst_ledr", LEDR, 32'h000);
        check("rst_hex0", HEX0, 32'hC0);
        check("rst_hex1", HEX1, 32'hC0);
        KEY[0] = 1'b1;
        cycles(3);
        check("idle_hex1", HEX1, 32'hC0);
        check("idle_ledr", LEDR, 32'h000);

        // 2. Manual transfer of A5
        base = nstrobe;
        do_load(8'hA5);
        check("load_ledr", LEDR, 32'h1A5);
        check("load_hex1", HEX1, 32'hA4);
        check("load_hex0", HEX0, 32'h80);
        for (int i = 0; i < 8; i++) begin
            press();
            check($sformatf("man_hex0_%0d", i), HEX0, {24'd0, seg_tab[7-i]});
        end
        check("man_bits", bits, 32'hA5);
        check("man_count", nstrobe - base, 32'd8);
        check("man_done_ledr", LEDR, 32'h200);
        check("man_done_hex1", HEX1, 32'hB0);

        // 3. Bounce: one step only (back-to-back load from DONE)
        base = nstrobe;
        do_load(8'h5A);
        KEY[1] = 1'b0; cycles(1);
        KEY[1] = 1'b1; cycles(1);
        KEY[1] = 1'b0; cycles(1);
        check("bounce_quiet", nstrobe - base, 32'd0);
        cycles(10);
        check("bounce_one", nstrobe - base, 32'd1);
        check("bounce_hex0", HEX0, 32'hF8);
        KEY[1] = 1'b1;
        cycles(10);
        check("bounce_still_one", nstrobe - base, 32'd1);
        for (int i = 0; i < 7; i++) press();
        check("bounce_bits", bits, 32'h5A);
        check("bounce_count", nstrobe - base, 32'd8);
        press();
        check("done_step_idle", HEX1, 32'hC0);

        // 4. Auto mode, 3C
        SW[9] = 1'b1;
        cycles(3);
        base = nstrobe;
        do_load(8'h3C);
        press();
        press();
        press();
        wait_done(200);
        check("auto_bits", bits, 32'h3C);
        check("auto_count", nstrobe - base, 32'd8);
        check("auto_shift_len", done_rise_cyc - shift_rise_cyc, 32'd80);
        for (int i = 0; i < 7; i++)
            check($sformatf("auto_gap_%0d", i),
                  strobe_cyc[base+i+1] - strobe_cyc[base+i], 32'd10);

        // 5. Ignored reload mid-transfer (back-to-back load from DONE)
        base = nstrobe;
        do_load(8'hF0);
        wait_strobes(base + 3, 100);
        SW[7:0] = 8'h0F;
        SW[8]   = 1'b1;
        cycles(5);
        check("reload_hex0", HEX0, 32'h92);
        check("reload_shreg", LEDR[7:0], 32'h80);
        check("reload_busy", {31'd0, LEDR[8]}, 32'd1);
        SW[8] = 1'b0;
        wait_done(200);
        check("reload_bits", bits, 32'hF0);
        check("reload_count", nstrobe - base, 32'd8);

        // 6. Reset after the 4th bit, then a fresh word
        do_load(8'hC3);
        seen = 0;
        for (int k = 0; k < 200 && seen < 4; k++) begin
            cycles(1);
            if (SER_VALID === 1'b1) seen++;
        end
        check("pre_rst_seen", seen, 32'd4);
        KEY[0] = 1'b0;
        #1;
        check("abort_valid", {31'd0, SER_VALID}, 32'd0);
        check("abort_hex1", HEX1, 32'hC0);
        check("abort_hex0", HEX0, 32'hC0);
        check("abort_ledr", LEDR, 32'h000);
        cycles(3);
        KEY[0] = 1'b1;
        cycles(3);
        check("post_rst_hex1", HEX1, 32'hC0);
        base = nstrobe;
        do_load(8'h81);
        wait_done(200);
        check("post_rst_bits", bits, 32'h81);
        check("post_rst_count", nstrobe - base, 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
